// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks (receiver here, transmitter on the far end).
package uart_pkg;

    // Receiver FSM states; also driven out on the debug state port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    // Sample indices (within a 16-sample bit) whose majority decides the bit value.
    localparam int MAJ_SAMPLE_LO = 7;
    localparam int MAJ_SAMPLE_HI = 9;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int uart_div(input int clock_freq, input int baud, input int os);
        return (clock_freq + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock o_tick every DIV clocks, restartable so the
// tick phase can be aligned to a detected start edge.
module uart_baud_tick #(
    parameter int DIV = 326
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));

    // Free-running divider; restart forces phase 0 so the first tick lands DIV clocks later.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_restart) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = w_wrap && !i_restart;

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver, LSB first, one stop bit. Bits are decided by a
// 3-of-samples majority (7,8,9). Received bytes are offered through a holding register.
//
// Handshake: o_rx_valid rises with a byte in o_rx_data and stays high, with o_rx_data
// stable, until a clock where i_rx_ready is also high; that clock transfers the byte.
// A byte completing on the transfer clock replaces it without a gap; a byte completing
// while the register is full and not being taken is dropped and flagged by o_overrun.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_frame_err,
    output logic                 o_break_det,
    output logic                 o_overrun,
    output logic                 o_busy,
    output uart_rx_state_t       o_state
);

    localparam int DIV = uart_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    // Synchronizer, edge detect and arming
    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_rx_d;
    logic [1:0]           r_fill;
    logic                 r_armed;
    logic                 w_fall;
    logic                 w_start;

    // Sampling
    logic                 w_tick;
    logic [3:0]           r_sample_cnt;
    logic [3:0]           w_idx;
    logic                 r_s7;
    logic                 r_s8;
    logic                 w_maj;
    logic                 w_decide;

    // FSM and datapath
    uart_rx_state_t       r_state;
    uart_rx_state_t       w_next_state;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_brk;
    logic                 r_ovr;

    // FSM output decodes
    logic                 w_shift;
    logic                 w_push;
    logic                 w_ovr;
    logic                 w_ferr;
    logic                 w_brk;
    logic                 w_busy;

    // Two-flop synchronizer plus one delay flop for falling-edge detection; idle-high reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    // Marks when r_rx_s carries real line data rather than its reset value, so a line
    // held low across reset never looks like a high-then-low start edge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_fill <= 2'b00;
        end else begin
            r_fill <= {r_fill[0], 1'b1};
        end
    end

    // Start edges are accepted only after the line has been seen high while idle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_armed <= 1'b0;
        end else if (w_brk) begin
            r_armed <= 1'b0;
        end else if (r_state == IDLE && r_rx_s && r_fill[1]) begin
            r_armed <= 1'b1;
        end
    end

    assign w_fall  = r_rx_d && !r_rx_s;
    assign w_start = (r_state == IDLE) && r_armed && w_fall;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_restart(w_start),
        .o_tick   (w_tick)
    );

    // The start edge is sample 0; each tick completes the next sample, wrapping per bit.
    assign w_idx = r_sample_cnt + 4'd1;

    // Sample counter aligned to the start edge.
    always_ff @(posedge i_clock) begin
        if (i_reset || w_start) begin
            r_sample_cnt <= 4'd0;
        end else if (w_tick) begin
            r_sample_cnt <= w_idx;
        end
    end

    // Capture the first two majority samples; the third is the live line at the decision.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s7 <= 1'b1;
            r_s8 <= 1'b1;
        end else if (w_tick) begin
            if (w_idx == 4'(MAJ_SAMPLE_LO)) begin
                r_s7 <= r_rx_s;
            end
            if (w_idx == 4'(MAJ_SAMPLE_LO + 1)) begin
                r_s8 <= r_rx_s;
            end
        end
    end

    assign w_maj    = (r_s7 & r_s8) | (r_s7 & r_rx_s) | (r_s8 & r_rx_s);
    assign w_decide = w_tick && (w_idx == 4'(MAJ_SAMPLE_HI)) && (r_state != IDLE);

    // FSM state register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; every bit decision happens on the sample-9 tick.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = START;
                end
            end
            START: begin
                if (w_decide) begin
                    w_next_state = w_maj ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_decide && r_bit_cnt == BW'(DATA_BITS - 1)) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_decide) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM output decodes: shift strobe and the stop-bit outcome strobes.
    always_comb begin
        w_shift = 1'b0;
        w_push  = 1'b0;
        w_ovr   = 1'b0;
        w_ferr  = 1'b0;
        w_brk   = 1'b0;
        w_busy  = (r_state != IDLE);
        case (r_state)
            DATA: begin
                w_shift = w_decide;
            end
            STOP: begin
                if (w_decide) begin
                    if (w_maj) begin
                        w_push = !r_valid || i_rx_ready;
                        w_ovr  = r_valid && !i_rx_ready;
                    end else begin
                        w_ferr = 1'b1;
                        w_brk  = (r_shreg == '0);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Data-bit counter and LSB-first shift register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_bit_cnt <= '0;
            r_shreg   <= '0;
        end else if (w_start) begin
            r_bit_cnt <= '0;
        end else if (w_shift) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_shreg   <= {w_maj, r_shreg[DATA_BITS-1:1]};
        end
    end

    // Holding register: load on a good stop bit, release on transfer.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_push) begin
            r_data  <= r_shreg;
            r_valid <= 1'b1;
        end else if (r_valid && i_rx_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Registered one-clock status pulses.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ferr <= 1'b0;
            r_brk  <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_brk  <= w_brk;
            r_ovr  <= w_ovr;
        end
    end

    assign o_rx_data   = r_data;
    assign o_rx_valid  = r_valid;
    assign o_frame_err = r_ferr;
    assign o_break_det = r_brk;
    assign o_overrun   = r_ovr;
    assign o_busy      = w_busy;
    assign o_state     = r_state;

endmodule
